// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage sitting behind the dc pipeline register. Issues loads
// and stores on a request/response data-SRAM interface, aligns and extends
// load data, and registers the writeback bundle for the wb stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush
//   stall[9:0]          stall vector; bit 7 = this stage, bit 8 = next stage (1 = stop)
//   dc_to_mem_bus       {valid, pc, ld_en, st_en, size, sign, rf_we, rf_waddr,
//                        addr_or_result, store_data}
//   data_req/wr/size/addr/wstrb/wdata   request side of the memory interface
//   data_addr_ok/data_ok/rdata          accept / response side
//   stallreq_mem        asks the pipeline to hold while a transaction is open
//   mem_to_wb_bus       {valid, pc, rf_we, rf_waddr, wdata}
//
// FSM states:
//   state   | meaning
//   IDLE    | no transaction outstanding; request driven for a pending op
//   WAIT    | request accepted, waiting for the response
//   DONE    | response captured in the buffer, held while this stage is stopped
//   DRAIN   | flushed while waiting; the late response is swallowed
module mem_stage #(
  parameter int DC_TO_MEM_WD = 108,
  parameter int MEM_TO_WB_WD = 71
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [9:0]              stall,
  input  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [31:0]             data_addr,
  output logic [3:0]              data_wstrb,
  output logic [31:0]             data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [31:0]             data_rdata,
  output logic                    stallreq_mem,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_rdata_buf;
  logic [MEM_TO_WB_WD-1:0] r_wb;

  logic        w_valid;
  logic [31:0] w_pc;
  logic        w_ld_en;
  logic        w_st_en;
  logic [1:0]  w_size;
  logic        w_sign;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_addr;
  logic [31:0] w_sd;

  assign w_valid    = dc_to_mem_bus[107];
  assign w_pc       = dc_to_mem_bus[106:75];
  assign w_ld_en    = dc_to_mem_bus[74];
  assign w_st_en    = dc_to_mem_bus[73];
  assign w_size     = dc_to_mem_bus[72:71];
  assign w_sign     = dc_to_mem_bus[70];
  assign w_rf_we    = dc_to_mem_bus[69];
  assign w_rf_waddr = dc_to_mem_bus[68:64];
  assign w_addr     = dc_to_mem_bus[63:32];
  assign w_sd       = dc_to_mem_bus[31:0];

  // Only the two stall bits belonging to this stage and the next are used.
  logic w_unused;
  assign w_unused = ^{stall[9], stall[6:0]};

  logic w_op;
  logic w_resp;
  logic w_stop;
  logic w_next_stop;

  assign w_op        = w_valid & (w_ld_en | w_st_en);
  assign w_resp      = (r_state == S_WAIT) & data_data_ok;
  assign w_stop      = stall[7];
  assign w_next_stop = stall[8];

  // Request is combinational from the held upstream register, so every
  // data_* field stays stable for as long as addr_ok is withheld.
  assign data_req     = ~rst & (r_state == S_IDLE) & w_op & ~flush;
  assign stallreq_mem = ~rst & w_op & ~flush & ~w_resp & (r_state != S_DONE);

  // Store formatting
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_data;

  always_comb begin
    w_st_strb = 4'b1111;
    w_st_data = w_sd;
    case (w_size)
      2'd0: begin
        w_st_strb = 4'b0001 << w_addr[1:0];
        w_st_data = {4{w_sd[7:0]}};
      end
      2'd1: begin
        w_st_strb = 4'b0011 << {w_addr[1], 1'b0};
        w_st_data = {2{w_sd[15:0]}};
      end
      default: begin
        w_st_strb = 4'b1111;
        w_st_data = w_sd;
      end
    endcase
  end

  assign data_wr    = w_st_en;
  assign data_size  = w_size;
  assign data_addr  = w_addr;
  assign data_wstrb = w_st_en ? w_st_strb : 4'b0000;
  assign data_wdata = w_st_data;

  // Load alignment: live response on the data_ok cycle, buffer otherwise.
  logic [31:0] w_ld_src;
  logic [31:0] w_byte_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign w_ld_src  = w_resp ? data_rdata : r_rdata_buf;
  assign w_byte_sh = w_ld_src >> {w_addr[1:0], 3'b000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_addr[1] ? w_ld_src[31:16] : w_ld_src[15:0];

  always_comb begin
    w_ld_data = w_ld_src;
    case (w_size)
      2'd0:    w_ld_data = {{24{w_sign & w_byte[7]}}, w_byte};
      2'd1:    w_ld_data = {{16{w_sign & w_half[15]}}, w_half};
      default: w_ld_data = w_ld_src;
    endcase
  end

  // An op still waiting on memory presents as a bubble (stallreq is high).
  logic                    w_new_valid;
  logic [31:0]             w_wb_data;
  logic [MEM_TO_WB_WD-1:0] w_wb_next;

  assign w_new_valid = w_valid & ~stallreq_mem;
  assign w_wb_data   = w_ld_en ? w_ld_data : w_addr;
  assign w_wb_next   = {w_new_valid, w_pc, w_rf_we, w_rf_waddr, w_wb_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdata_buf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_req & data_addr_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            r_rdata_buf <= data_rdata;
            if (!flush && w_stop) r_state <= S_DONE;
            else                  r_state <= S_IDLE;
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (flush || !w_stop) r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (data_data_ok) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_wb <= '0;
    else if (flush)                r_wb <= '0;
    else if (w_stop & ~w_next_stop) r_wb <= '0;
    else if (!w_stop)              r_wb <= w_wb_next;
  end

  assign mem_to_wb_bus = r_wb;

endmodule
